video_system_cpu_oci_dct_packer: RTL and testbench

Packs 2-bit CPU debug-trace codes from the Nios II OCI trace path into 30-bit words (15 slots) with a 4-bit valid-slot count. Drives `dct_buffer`/`dct_count` into the OCI test bench and any downstream trace sink through a one-entry valid/ready output register. Also handles flush and end-of-test draining, and reports `test_has_ended` once every accepted code has been handed off.

---
 rtl/video_system_cpu_oci_dct_pkg.sv | 44 ++++
 rtl/video_system_cpu_oci_dct_outreg.sv | 39 +++
 rtl/video_system_cpu_oci_dct_packer.sv | 157 +++++++++++++++
 tb/tb_video_system_cpu_oci_dct_packer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/video_system_cpu_oci_dct_pkg.sv
// Shared widths, state encoding and slot helper for the OCI debug-trace packer.
package video_system_cpu_oci_dct_pkg;

  localparam int SLOTS  = 15;
  localparam int CODE_W = 2;
  localparam int WORD_W = SLOTS * CODE_W;
  localparam int CNT_W  = $clog2(SLOTS + 1);
  localparam int DROP_W = 8;

  localparam logic [CODE_W-1:0] TRC_IDLE   = 2'd0;
  localparam logic [CODE_W-1:0] TRC_BRANCH = 2'd1;
  localparam logic [CODE_W-1:0] TRC_EXCEPT = 2'd2;
  localparam logic [CODE_W-1:0] TRC_SYNC   = 2'd3;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    ENDING = 2'd1,
    ENDED  = 2'd2
  } dct_state_e;

  typedef struct packed {
    logic [WORD_W-1:0] buffer;
    logic [CNT_W-1:0]  count;
  } dct_word_t;

  // Write one code into slot idx; every other slot is carried through untouched.
  function automatic logic [WORD_W-1:0] slot_insert(
    input logic [WORD_W-1:0] word,
    input logic [CNT_W-1:0]  idx,
    input logic [CODE_W-1:0] code
  );
    logic [WORD_W-1:0] res;
    res = word;
    for (int k = 0; k < SLOTS; k++) begin
      if (idx == CNT_W'(k)) begin
        res[k*CODE_W +: CODE_W] = code;
      end else begin
        res[k*CODE_W +: CODE_W] = word[k*CODE_W +: CODE_W];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/video_system_cpu_oci_dct_outreg.sv
// One-entry valid/ready output register for packed trace words.
module video_system_cpu_oci_dct_outreg
  import video_system_cpu_oci_dct_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      load,
  input  dct_word_t load_word,
  input  logic      ready,
  output logic      valid,
  output dct_word_t word,
  output logic      free
);

  logic      valid_r;
  dct_word_t word_r;

  assign valid = valid_r;
  assign word  = word_r;
  assign free  = !valid_r || ready;

  // Load has priority: a new word may replace the one handed off on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_r <= 1'b0;
      word_r  <= '0;
    end else if (load) begin
      valid_r <= 1'b1;
      word_r  <= load_word;
    end else if (ready) begin
      valid_r <= 1'b0;
      word_r  <= word_r;
    end else begin
      valid_r <= valid_r;
      word_r  <= word_r;
    end
  end

endmodule

// File: rtl/video_system_cpu_oci_dct_packer.sv
// Packs 2-bit trace codes into 15-slot words, with flush, drop accounting
// and an end-of-test drain that reports when every accepted code has left.
module video_system_cpu_oci_dct_packer
  import video_system_cpu_oci_dct_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              trc_valid,
  input  logic [CODE_W-1:0] trc_code,
  input  logic              flush,
  input  logic              test_ending,
  input  logic              dct_ready,
  output logic              dct_valid,
  output logic [WORD_W-1:0] dct_buffer,
  output logic [CNT_W-1:0]  dct_count,
  output logic              overflow,
  output logic [DROP_W-1:0] drop_count,
  output logic              test_has_ended
);

  dct_state_e        state_r;
  logic [WORD_W-1:0] acc_r;
  logic [CNT_W-1:0]  acc_cnt_r;
  logic              flush_pend_r;
  logic              overflow_r;
  logic [DROP_W-1:0] drop_count_r;
  logic              ended_r;

  logic [WORD_W-1:0] acc_nxt_s;
  logic [WORD_W-1:0] acc_code_s;
  logic [CNT_W-1:0]  acc_cnt_nxt_s;
  logic [CNT_W-1:0]  cnt_code_s;
  logic              pend_s;
  logic              free_s;
  logic              held_s;
  logic              accept_s;
  logic              drop_s;
  logic              xfer_s;
  dct_word_t         xfer_word_s;
  dct_word_t         out_word_s;

  assign held_s = (acc_cnt_r == CNT_W'(SLOTS));

  // Accept/drop decision, accumulator update and word-transfer selection.
  always_comb begin
    accept_s      = 1'b0;
    drop_s        = 1'b0;
    xfer_s        = 1'b0;
    xfer_word_s   = '0;
    acc_code_s    = acc_r;
    cnt_code_s    = acc_cnt_r;
    acc_nxt_s     = acc_r;
    acc_cnt_nxt_s = acc_cnt_r;
    pend_s        = flush_pend_r || flush || ((state_r == RUN) && test_ending);

    if ((state_r == RUN) && trc_valid) begin
      if (held_s && !free_s) begin
        drop_s = 1'b1;
      end else begin
        accept_s = 1'b1;
      end
    end else begin
      accept_s = 1'b0;
      drop_s   = 1'b0;
    end

    if (held_s) begin
      // A held full word leaves first; a code arriving alongside starts the next word.
      if (free_s) begin
        xfer_s        = 1'b1;
        xfer_word_s   = '{buffer: acc_r, count: acc_cnt_r};
        acc_nxt_s     = accept_s ? slot_insert('0, '0, trc_code) : '0;
        acc_cnt_nxt_s = accept_s ? CNT_W'(1) : '0;
      end else begin
        acc_nxt_s     = acc_r;
        acc_cnt_nxt_s = acc_cnt_r;
      end
    end else begin
      acc_code_s = accept_s ? slot_insert(acc_r, acc_cnt_r, trc_code) : acc_r;
      cnt_code_s = acc_cnt_r + CNT_W'(accept_s);
      if (free_s && ((cnt_code_s == CNT_W'(SLOTS)) || (pend_s && (cnt_code_s != '0)))) begin
        xfer_s        = 1'b1;
        xfer_word_s   = '{buffer: acc_code_s, count: cnt_code_s};
        acc_nxt_s     = '0;
        acc_cnt_nxt_s = '0;
      end else begin
        acc_nxt_s     = acc_code_s;
        acc_cnt_nxt_s = cnt_code_s;
      end
    end
  end

  // Accumulator, flush request, drop accounting and drain state machine.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= RUN;
      acc_r        <= '0;
      acc_cnt_r    <= '0;
      flush_pend_r <= 1'b0;
      overflow_r   <= 1'b0;
      drop_count_r <= '0;
      ended_r      <= 1'b0;
    end else begin
      acc_r        <= acc_nxt_s;
      acc_cnt_r    <= acc_cnt_nxt_s;
      // A pending flush survives only while codes remain behind a blocked output.
      flush_pend_r <= pend_s && (acc_cnt_nxt_s != '0);
      overflow_r   <= overflow_r || drop_s;
      if (drop_s && (drop_count_r != {DROP_W{1'b1}})) begin
        drop_count_r <= drop_count_r + DROP_W'(1);
      end else begin
        drop_count_r <= drop_count_r;
      end
      case (state_r)
        RUN: begin
          state_r <= test_ending ? ENDING : RUN;
          ended_r <= 1'b0;
        end
        ENDING: begin
          if ((acc_cnt_r == '0) && !flush_pend_r && free_s && !xfer_s) begin
            state_r <= ENDED;
            ended_r <= 1'b1;
          end else begin
            state_r <= ENDING;
            ended_r <= 1'b0;
          end
        end
        ENDED: begin
          state_r <= ENDED;
          ended_r <= 1'b1;
        end
        default: begin
          state_r <= RUN;
          ended_r <= 1'b0;
        end
      endcase
    end
  end

  video_system_cpu_oci_dct_outreg u_outreg (
    .clk       (clk),
    .reset     (reset),
    .load      (xfer_s),
    .load_word (xfer_word_s),
    .ready     (dct_ready),
    .valid     (dct_valid),
    .word      (out_word_s),
    .free      (free_s)
  );

  assign dct_buffer     = out_word_s.buffer;
  assign dct_count      = out_word_s.count;
  assign overflow       = overflow_r;
  assign drop_count     = drop_count_r;
  assign test_has_ended = ended_r;

endmodule

// File: tb/tb_video_system_cpu_oci_dct_packer.sv
// Directed bench: a small packing model queues expected words as codes are driven;
// a negedge monitor pops and compares them at each handshake.
module tb_video_system_cpu_oci_dct_packer;

  logic        clk = 1'b0;
  logic        reset;
  logic        trc_valid;
  logic [1:0]  trc_code;
  logic        flush;
  logic        test_ending;
  logic        dct_ready;
  logic        dct_valid;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        overflow;
  logic [7:0]  drop_count;
  logic        test_has_ended;

  int          n_total = 0;
  int          n_pass  = 0;
  logic [33:0] exp_q[$];
  logic [29:0] m_acc;
  logic [3:0]  m_cnt;
  logic        hold_prev = 1'b0;
  logic [29:0] held_buf;
  logic [3:0]  held_cnt;
  logic [33:0] exp_word;

  always #5 clk = ~clk;

  video_system_cpu_oci_dct_packer dut (
    .clk            (clk),
    .reset          (reset),
    .trc_valid      (trc_valid),
    .trc_code       (trc_code),
    .flush          (flush),
    .test_ending    (test_ending),
    .dct_ready      (dct_ready),
    .dct_valid      (dct_valid),
    .dct_buffer     (dct_buffer),
    .dct_count      (dct_count),
    .overflow       (overflow),
    .drop_count     (drop_count),
    .test_has_ended (test_has_ended)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic model_code(input logic [1:0] c);
    m_acc[int'(m_cnt)*2 +: 2] = c;
    m_cnt = m_cnt + 4'd1;
  endtask

  task automatic model_close();
    exp_q.push_back({m_acc, m_cnt});
    m_acc = '0;
    m_cnt = '0;
  endtask

  // Handshake scoreboard and stability of a word held by back-pressure.
  always @(negedge clk) begin
    if (!reset && dct_valid) begin
      if (hold_prev) begin
        check("hold_buffer", 32'(dct_buffer), 32'(held_buf));
        check("hold_count", 32'(dct_count), 32'(held_cnt));
      end
      if (dct_ready) begin
        check("word_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          exp_word = exp_q.pop_front();
          check("word_buffer", 32'(dct_buffer), 32'(exp_word[33:4]));
          check("word_count", 32'(dct_count), 32'(exp_word[3:0]));
        end
      end
      hold_prev = !dct_ready;
      held_buf  = dct_buffer;
      held_cnt  = dct_count;
    end else begin
      hold_prev = 1'b0;
    end
  end

  initial begin
    reset = 1'b1; trc_valid = 1'b0; trc_code = 2'd0; flush = 1'b0;
    test_ending = 1'b0; dct_ready = 1'b0; m_acc = '0; m_cnt = '0;
    tick(); tick();
    reset = 1'b0;
    check("rst_valid", 32'(dct_valid), 32'd0);
    check("rst_buffer", 32'(dct_buffer), 32'd0);
    check("rst_count", 32'(dct_count), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_drops", 32'(drop_count), 32'd0);
    check("rst_ended", 32'(test_has_ended), 32'd0);

    // Full word at one code per cycle, valid right after the 15th code.
    dct_ready = 1'b1;
    for (int k = 0; k < 15; k++) begin
      trc_valid = 1'b1; trc_code = 2'(k % 4);
      model_code(trc_code);
      if (k == 14) model_close();
      tick();
      check("full_latency", 32'(dct_valid), 32'(k == 14));
    end
    trc_valid = 1'b0;
    check("full_buffer", 32'(dct_buffer), 32'h24E4E4E4);
    check("full_count", 32'(dct_count), 32'd15);
    tick();
    check("full_drained", 32'(dct_valid), 32'd0);

    // Partial word by flush, then a flush with nothing accumulated.
    for (int k = 1; k <= 3; k++) begin
      trc_valid = 1'b1; trc_code = 2'(k);
      model_code(trc_code);
      tick();
    end
    trc_valid = 1'b0;
    check("partial_not_early", 32'(dct_valid), 32'd0);
    flush = 1'b1; model_close();
    tick();
    flush = 1'b0;
    check("flush_valid", 32'(dct_valid), 32'd1);
    check("flush_count", 32'(dct_count), 32'd3);
    check("flush_upper_zero", 32'(dct_buffer[29:6]), 32'd0);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("empty_flush", 32'(dct_valid), 32'd0);
    tick();
    check("empty_flush_late", 32'(dct_valid), 32'd0);

    // Back-pressure: one word out, one held full, two codes dropped.
    dct_ready = 1'b0;
    for (int k = 0; k < 32; k++) begin
      trc_valid = 1'b1; trc_code = 2'(k % 4);
      if (k < 30) model_code(trc_code);
      if (k == 14 || k == 29) model_close();
      tick();
      if (k == 14) check("blocked_first_valid", 32'(dct_valid), 32'd1);
    end
    trc_valid = 1'b0;
    check("blocked_overflow", 32'(overflow), 32'd1);
    check("blocked_drops", 32'(drop_count), 32'd2);
    check("blocked_count", 32'(dct_count), 32'd15);

    // Release with a code in the same cycle: it starts the next word in slot 0.
    dct_ready = 1'b1; trc_valid = 1'b1; trc_code = 2'd3;
    model_code(trc_code);
    tick();
    trc_valid = 1'b0;
    check("second_word_valid", 32'(dct_valid), 32'd1);
    check("second_word_count", 32'(dct_count), 32'd15);
    tick();
    check("slot0_no_word", 32'(dct_valid), 32'd0);
    flush = 1'b1; model_close();
    tick();
    flush = 1'b0;
    check("slot0_count", 32'(dct_count), 32'd1);
    check("slot0_buffer", 32'(dct_buffer), 32'd3);
    tick();
    check("drops_kept", 32'(drop_count), 32'd2);

    // End of test drains a partial word held by back-pressure.
    for (int k = 0; k < 5; k++) begin
      trc_valid = 1'b1; trc_code = 2'(3 - (k % 4));
      model_code(trc_code);
      tick();
    end
    trc_valid = 1'b0;
    check("ending_pending", 32'(dct_valid), 32'd0);
    dct_ready = 1'b0; test_ending = 1'b1; model_close();
    tick();
    test_ending = 1'b0;
    check("ending_valid", 32'(dct_valid), 32'd1);
    check("ending_count", 32'(dct_count), 32'd5);
    trc_valid = 1'b1; trc_code = 2'd1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("ending_held_count", 32'(dct_count), 32'd5);
      check("ending_not_ended", 32'(test_has_ended), 32'd0);
    end
    trc_valid = 1'b0;
    check("ending_drops_same", 32'(drop_count), 32'd2);
    dct_ready = 1'b1;
    tick();
    tick();
    check("ended_flag", 32'(test_has_ended), 32'd1);
    check("ended_idle", 32'(dct_valid), 32'd0);
    trc_valid = 1'b1;
    tick(); tick(); tick();
    trc_valid = 1'b0;
    check("ended_ignores", 32'(dct_valid), 32'd0);

    // Reset clears sticky flags, then reset mid-word discards everything.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst2_overflow", 32'(overflow), 32'd0);
    check("rst2_ended", 32'(test_has_ended), 32'd0);
    dct_ready = 1'b0;
    for (int k = 0; k < 22; k++) begin
      trc_valid = 1'b1; trc_code = 2'(k % 4);
      tick();
    end
    trc_valid = 1'b0;
    check("midword_valid", 32'(dct_valid), 32'd1);
    reset = 1'b1; exp_q.delete(); m_acc = '0; m_cnt = '0;
    tick();
    reset = 1'b0;
    check("rst3_valid", 32'(dct_valid), 32'd0);
    check("rst3_buffer", 32'(dct_buffer), 32'd0);
    check("rst3_count", 32'(dct_count), 32'd0);
    check("rst3_drops", 32'(drop_count), 32'd0);
    dct_ready = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0;
    check("acc_discarded", 32'(dct_valid), 32'd0);
    test_ending = 1'b1;
    tick();
    test_ending = 1'b0;
    check("empty_end_not_yet", 32'(test_has_ended), 32'd0);
    tick();
    check("empty_end_flag", 32'(test_has_ended), 32'd1);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
